// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the board LED controller.
// Holds the ownership state encoding and the heartbeat step rules.
package led_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CPU  = 2'd1,
      DBG  = 2'd2
   } state_t;

   localparam logic HB_BLINK = 1'b0;
   localparam logic HB_CHASE = 1'b1;

   function automatic logic onehot8(input logic [7:0] v);
      return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
   endfunction

   // Next heartbeat value; any stale pattern restarts cleanly.
   function automatic logic [7:0] hb_step(
      input logic       mode,
      input logic [7:0] hb
   );
      logic [7:0] nxt;
      nxt = 8'h00;
      if (mode == HB_CHASE) begin
         if (onehot8(hb)) nxt = {hb[6:0], hb[7]};
         else             nxt = 8'h01;
      end else begin
         if (hb != 8'h00) nxt = 8'h00;
         else             nxt = 8'hFF;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/led_ctrl_tick.sv
// Prescaler: one-cycle tick every TICK_DIV clocks.
// Free-running; only reset restarts the phase.
module led_tick_gen #(
   parameter int unsigned TICK_DIV = 25000000
) (
   input  logic CLOCK_50,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge CLOCK_50) begin
      if (reset || tick) cnt <= '0;
      else               cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/led_ctrl.sv
// Arbitrates the green LEDs between CPU and debug port,
// with a heartbeat when idle and revocation of silent owners.
module led_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int unsigned TICK_DIV      = 25000000,
   parameter int unsigned TIMEOUT_TICKS = 8
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       hb_mode,
   input  logic       cpu_req,
   input  logic       cpu_we,
   input  logic [7:0] cpu_data,
   output logic       cpu_gnt,
   input  logic       dbg_req,
   input  logic       dbg_we,
   input  logic [7:0] dbg_data,
   output logic       dbg_gnt,
   output logic       timeout,
   output logic [7:0] LEDG
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_TICKS - 1);

   state_t     state;
   logic       tick;
   logic [7:0] hb;
   logic [7:0] latch;
   logic [7:0] tcnt;
   logic       lock_cpu;
   logic       lock_dbg;

   logic       own_req;
   logic       own_we;
   logic [7:0] own_data;

   led_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick (
      .CLOCK_50(CLOCK_50),
      .reset   (reset),
      .tick    (tick)
   );

   always_comb begin
      own_req  = 1'b0;
      own_we   = 1'b0;
      own_data = 8'h00;
      unique case (state)
         CPU: begin
            own_req  = cpu_req;
            own_we   = cpu_req & cpu_we;
            own_data = cpu_data;
         end
         DBG: begin
            own_req  = dbg_req;
            own_we   = dbg_req & dbg_we;
            own_data = dbg_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state    <= IDLE;
         cpu_gnt  <= 1'b0;
         dbg_gnt  <= 1'b0;
         timeout  <= 1'b0;
         LEDG     <= 8'h00;
         hb       <= 8'h00;
         latch    <= 8'h00;
         tcnt     <= 8'h00;
         lock_cpu <= 1'b0;
         lock_dbg <= 1'b0;
      end else begin
         timeout <= 1'b0;
         LEDG    <= (state == IDLE) ? hb : latch;
         if (tick) hb <= hb_step(hb_mode, hb);
         if (!cpu_req) lock_cpu <= 1'b0;
         if (!dbg_req) lock_dbg <= 1'b0;

         unique case (state)
            IDLE: begin
               if (cpu_req && !lock_cpu) begin
                  state   <= CPU;
                  cpu_gnt <= 1'b1;
                  latch   <= 8'h00;
                  tcnt    <= 8'h00;
               end else if (dbg_req && !lock_dbg) begin
                  state   <= DBG;
                  dbg_gnt <= 1'b1;
                  latch   <= 8'h00;
                  tcnt    <= 8'h00;
               end
            end
            CPU, DBG: begin
               if (!own_req) begin
                  state   <= IDLE;
                  cpu_gnt <= 1'b0;
                  dbg_gnt <= 1'b0;
               end else if (own_we) begin
                  latch <= own_data;
                  tcnt  <= 8'h00;
               end else if (tick) begin
                  // Terminal tick with no write: revoke and lock out.
                  if (tcnt == TO_LAST) begin
                     state   <= IDLE;
                     cpu_gnt <= 1'b0;
                     dbg_gnt <= 1'b0;
                     timeout <= 1'b1;
                     if (state == CPU) lock_cpu <= 1'b1;
                     else              lock_dbg <= 1'b1;
                  end else begin
                     tcnt <= tcnt + 8'h01;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               cpu_gnt <= 1'b0;
               dbg_gnt <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/led_ctrl.md
Name: led_ctrl

Overview:
- Owns the 8 green board LEDs and arbitrates them between two requesters: the CPU status port and the debug port.
- When neither requester holds the LEDs, shows a free-running heartbeat pattern (blink or chase) paced by a prescaled tick from CLOCK_50.
- Revokes ownership from a requester that stops writing, so a hung requester cannot freeze the display.
- Sits between the CPU core and the board LED pins in the on-board top level.

Parameters:
- TICK_DIV, 25000000: CLOCK_50 cycles per heartbeat tick (0.5 s). Benches override with a small value.
- TIMEOUT_TICKS, 8: consecutive ticks without an accepted write before the owner is revoked. Range 1..255.

Ports:
- CLOCK_50  in  1  single system clock (50 MHz).
- reset  in  1  synchronous, active-high reset. The top level derives it from the debounced, inverted KEY0.
- hb_mode  in  1  heartbeat pattern select: 0 = blink, 1 = chase.
- cpu_req  in  1  CPU requests the LEDs; held high for as long as it wants ownership.
- cpu_we  in  1  CPU write strobe.
- cpu_data  in  8  CPU LED value.
- cpu_gnt  out  1  CPU owns the LEDs.
- dbg_req  in  1  debug port request.
- dbg_we  in  1  debug port write strobe.
- dbg_data  in  8  debug port LED value.
- dbg_gnt  out  1  debug port owns the LEDs.
- timeout  out  1  one-cycle pulse when an owner is revoked.
- LEDG  out  8  registered LED drive.

Behaviour:
- Reset (synchronous, one edge):
  - LEDG=0x00, cpu_gnt=0, dbg_gnt=0, timeout=0.
  - state=IDLE; tick counter, timeout counter, hb register and owner latch all 0; both lockout flags clear.
- Tick:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick pulses for one cycle when the counter equals TICK_DIV-1.
  - Free-running in every state; only reset clears it.
- Heartbeat register hb (updates on tick in every state):
  - Blink: if hb != 0x00, load 0x00; otherwise load 0xFF.
  - Chase: if hb is exactly one-hot, rotate left (0x80 -> 0x01); otherwise load 0x01.
  - A hb_mode change takes effect at the next tick using these rules.
- States: IDLE, CPU, DBG. The grant outputs are registered.
  - cpu_gnt=1 exactly when state=CPU; dbg_gnt=1 exactly when state=DBG.
- IDLE:
  - If cpu_req=1 and the CPU lockout is clear: go to CPU. The CPU wins when both request.
  - Else if dbg_req=1 and the debug lockout is clear: go to DBG.
  - Grant latency is one cycle after req is sampled.
  - On grant: owner latch=0x00, timeout counter=0.
- CPU / DBG:
  - If the owner's req=0: go to IDLE next cycle. No preemption and no direct CPU<->DBG handoff; the other requester gets the grant one cycle later via IDLE.
  - Write accepted only when gnt=1, req=1 and we=1 in the same cycle. Accepted data goes to the owner latch, the timeout counter clears, and LEDG shows the value on the following cycle.
  - Writes from the non-owner, or while req=0, are ignored.
  - On a tick with no accepted write that cycle, the timeout counter increments.
  - When the counter reaches TIMEOUT_TICKS: go to IDLE, pulse timeout for one cycle (aligned with gnt falling), and set the owner's lockout flag.
  - An accepted write in the same cycle as the terminal tick wins: the counter clears and there is no revoke.
- Lockout:
  - The flag clears on the first cycle its req is sampled low.
  - While the flag is set, that requester cannot be granted and the other requester may be.
- LEDG (registered):
  - IDLE: LEDG <= hb.
  - CPU / DBG: LEDG <= owner latch (so 0x00 until the first write).
  - Net effect: LEDG changes one cycle after the state or hb change that causes it.
- Reset mid-ownership: one edge returns every output to its reset value; any pending write is lost.

Decomposition:
- Package led_ctrl_pkg:
  - State enum {IDLE, CPU, DBG}.
  - Constants HB_BLINK=1'b0, HB_CHASE=1'b1.
  - Function onehot8.
- Sub-module led_tick_gen:
  - Parameter TICK_DIV; ports CLOCK_50, reset, tick.
  - Also reused by other board-level blocks.

Test Plan (all scenarios: TICK_DIV=4, TIMEOUT_TICKS=3):
1. Reset, hb_mode=0, no requests, run 20 cycles -> LEDG sequence 0x00, 0xFF, 0x00, ..., each change 1 cycle after a tick; grants stay 0.
2. hb_mode=1 from reset -> LEDG 0x01, 0x02, ..., 0x80, 0x01 on successive ticks. Switch to blink while LEDG=0x04 -> next tick gives 0x00.
3. cpu_req and dbg_req rise in the same cycle -> cpu_gnt=1 next cycle, dbg_gnt=0.
   - cpu_we with 0xA5 -> LEDG=0xA5 one cycle later.
   - Drop cpu_req -> IDLE, then dbg_gnt=1 one cycle after that; LEDG=0x00 until the debug port writes.
4. dbg_we with 0x3C while cpu_gnt=1 -> ignored; LEDG holds the CPU value.
5. CPU granted, writes 0x11, then no writes -> on the 3rd tick timeout pulses for 1 cycle, cpu_gnt=0, LEDG returns to hb.
   - cpu_req held high -> no re-grant.
   - Drop cpu_req for 1 cycle, raise again -> granted.
6. Assert reset while dbg_gnt=1 and LEDG=0x5A -> next cycle all outputs at reset values and state=IDLE.
